// File: rtl/key_event_decoder.sv
// Keypad event decoder: turns the encoder's code/strobe level into press and
// hold-to-repeat events, pulses them one-hot and queues them for the consumer.
module key_event_decoder #(
  parameter int DEPTH        = 4,
  parameter int REPEAT_DELAY = 1000,
  parameter int REPEAT_RATE  = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  code,
  input  logic        strobe,
  output logic [19:0] key_onehot,
  output logic        key_pulse,
  output logic        ev_valid,
  output logic [4:0]  ev_code,
  output logic        ev_repeat,
  input  logic        ev_ready,
  output logic        overflow,
  input  logic        clear_ovf
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DLY_LAST  = CW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic          strobe_q;
  logic          press;
  logic          fire;
  logic          fire_rep;
  logic          push;

  logic [5:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic [5:0]    head;

  assign press = strobe & ~strobe_q;

  // A release always wins over a repeat tick landing in the same cycle.
  always_comb begin
    fire     = 1'b0;
    fire_rep = 1'b0;
    unique case (state)
      IDLE:   fire = press;
      DELAY:  if (strobe && REPEAT_DELAY != 0 && counter == DLY_LAST) begin
                fire     = 1'b1;
                fire_rep = 1'b1;
              end
      REPEAT: if (strobe && counter == RATE_LAST) begin
                fire     = 1'b1;
                fire_rep = 1'b1;
              end
      default: ;
    endcase
  end

  assign push = fire & (code < 5'd20);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      counter    <= '0;
      strobe_q   <= 1'b0;
      key_onehot <= '0;
      key_pulse  <= 1'b0;
    end else begin
      strobe_q   <= strobe;
      key_pulse  <= push;
      key_onehot <= push ? (20'd1 << code) : 20'd0;
      unique case (state)
        IDLE: begin
          if (press) begin
            state   <= DELAY;
            counter <= '0;
          end
        end
        DELAY: begin
          if (!strobe) begin
            state   <= IDLE;
            counter <= '0;
          end else if (fire) begin
            state   <= REPEAT;
            counter <= '0;
          end else if (REPEAT_DELAY != 0) begin
            counter <= counter + 1'b1;
          end
        end
        REPEAT: begin
          if (!strobe) begin
            state   <= IDLE;
            counter <= '0;
          end else if (fire) begin
            counter <= '0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & ev_ready;
  assign wr_en = push & (~full | pop);

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {fire_rep, code};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      else if (clear_ovf)       overflow <= 1'b0;
    end
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign ev_valid  = ~empty;
  assign ev_code   = empty ? 5'd0 : head[4:0];
  assign ev_repeat = empty ? 1'b0 : head[5];

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: stimulus queues expected pulses and
// FIFO entries, independent monitors compare them as the DUT presents them.
module tb_key_event_decoder;

  localparam int DEPTH = 4;
  localparam int DLY   = 8;
  localparam int RATE  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  code;
  logic        strobe;
  logic [19:0] key_onehot;
  logic        key_pulse;
  logic        ev_valid;
  logic [4:0]  ev_code;
  logic        ev_repeat;
  logic        ev_ready;
  logic        overflow;
  logic        clear_ovf;

  typedef struct packed {
    logic [31:0] cyc;
    logic [4:0]  code;
    logic        rep;
  } pulse_t;

  pulse_t     pulse_q [$];
  logic [5:0] fifo_q  [$];
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;

  key_event_decoder #(.DEPTH(DEPTH), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)) dut (
    .clk(clk), .rst(rst), .code(code), .strobe(strobe),
    .key_onehot(key_onehot), .key_pulse(key_pulse),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_repeat(ev_repeat),
    .ev_ready(ev_ready), .overflow(overflow), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [4:0] c);
    strobe = s;
    code   = c;
  endtask

  // Strobe rises before edge n+1 and stays high through edge n+hold.
  task automatic expectPress(input logic [4:0] c, input int n, input int hold, input bit to_fifo);
    pulse_t e;
    int     t;
    if (c < 20) begin
      e = '{cyc: n + 1, code: c, rep: 1'b0};
      pulse_q.push_back(e);
      if (to_fifo) fifo_q.push_back({1'b0, c});
      t = n + 1 + DLY;
      while (DLY > 0 && t <= n + hold) begin
        e = '{cyc: t, code: c, rep: 1'b1};
        pulse_q.push_back(e);
        if (to_fifo) fifo_q.push_back({1'b1, c});
        t += RATE;
      end
    end
  endtask

  task automatic startPress(input logic [4:0] c, input int hold, input bit to_fifo);
    expectPress(c, cyc, hold, to_fifo);
    applyStimulus(1'b1, c);
  endtask

  task automatic pressKey(input logic [4:0] c, input int hold, input bit to_fifo);
    startPress(c, hold, to_fifo);
    tick(hold);
    applyStimulus(1'b0, c);
    tick(2);
  endtask

  // Monitor: one-hot pulse stream and FIFO head, sampled on the falling edge.
  always @(negedge clk) begin
    pulse_t e;
    logic [19:0] exp1h;
    checkOutput("pulse_vs_onehot", {31'd0, key_pulse}, {31'd0, key_onehot != 20'd0});
    if (key_pulse) begin
      if (pulse_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: got onehot 0x%0h expected none at cycle %0d", key_onehot, cyc);
      end else begin
        e = pulse_q.pop_front();
        exp1h = 20'd1 << e.code;
        checkOutput("pulse_cycle", cyc, e.cyc);
        checkOutput("key_onehot", {12'd0, key_onehot}, {12'd0, exp1h});
      end
    end
    if (ev_valid && ev_ready) begin
      if (fifo_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event: got code %0d rep %0b expected none", ev_code, ev_repeat);
      end else begin
        checkOutput("ev_entry", {26'd0, ev_repeat, ev_code}, {26'd0, fifo_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b0; ev_ready = 1'b0; clear_ovf = 1'b0;
    applyStimulus(1'b0, 5'd0);
    #12;
    checkOutput("rst_onehot", {12'd0, key_onehot}, 32'd0);
    checkOutput("rst_pulse", {31'd0, key_pulse}, 32'd0);
    checkOutput("rst_valid", {31'd0, ev_valid}, 32'd0);
    checkOutput("rst_code", {27'd0, ev_code}, 32'd0);
    checkOutput("rst_repeat", {31'd0, ev_repeat}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    tick(1);
    rst = 1'b1;
    tick(2);

    $display("[TB] single press of code 7");
    ev_ready = 1'b1;
    pressKey(5'd7, 6, 1'b1);
    tick(4);

    $display("[TB] hold code 19 for repeats");
    pressKey(5'd19, 20, 1'b1);
    tick(4);

    $display("[TB] overflow with consumer stalled");
    ev_ready = 1'b0;
    pressKey(5'd1, 2, 1'b1);
    pressKey(5'd2, 2, 1'b1);
    pressKey(5'd3, 2, 1'b1);
    pressKey(5'd4, 2, 1'b1);
    pressKey(5'd5, 2, 1'b0);
    checkOutput("ovf_set", {31'd0, overflow}, 32'd1);
    checkOutput("ovf_head", {27'd0, ev_code}, 32'd1);
    ev_ready = 1'b1;
    tick(6);
    checkOutput("drained_valid", {31'd0, ev_valid}, 32'd0);
    checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
    checkOutput("ovf_cleared", {31'd0, overflow}, 32'd0);

    $display("[TB] push and pop together while full");
    ev_ready = 1'b0;
    pressKey(5'd8, 2, 1'b1);
    pressKey(5'd9, 2, 1'b1);
    pressKey(5'd10, 2, 1'b1);
    pressKey(5'd11, 2, 1'b1);
    ev_ready = 1'b1;
    startPress(5'd12, 2, 1'b1);
    tick(1);
    ev_ready = 1'b0;
    tick(1);
    applyStimulus(1'b0, 5'd12);
    tick(2);
    checkOutput("full_pp_ovf", {31'd0, overflow}, 32'd0);
    checkOutput("full_pp_valid", {31'd0, ev_valid}, 32'd1);
    checkOutput("full_pp_head", {26'd0, ev_repeat, ev_code}, {26'd0, 6'd9});
    ev_ready = 1'b1;
    tick(6);
    checkOutput("full_pp_drained", {31'd0, ev_valid}, 32'd0);

    $display("[TB] invalid code then code 0");
    pressKey(5'd25, 12, 1'b0);
    pressKey(5'd0, 2, 1'b1);
    tick(2);

    $display("[TB] asynchronous reset while repeating");
    ev_ready = 1'b0;
    startPress(5'd3, 12, 1'b0);
    tick(13);
    checkOutput("pre_rst_pulse", {31'd0, key_pulse}, 32'd1);
    checkOutput("pre_rst_valid", {31'd0, ev_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_onehot", {12'd0, key_onehot}, 32'd0);
    checkOutput("mid_rst_pulse", {31'd0, key_pulse}, 32'd0);
    checkOutput("mid_rst_valid", {31'd0, ev_valid}, 32'd0);
    checkOutput("mid_rst_code", {27'd0, ev_code}, 32'd0);
    checkOutput("mid_rst_repeat", {31'd0, ev_repeat}, 32'd0);
    ev_ready = 1'b1;
    tick(2);
    rst = 1'b1;
    expectPress(5'd3, cyc, 2, 1'b1);
    tick(2);
    applyStimulus(1'b0, 5'd3);
    tick(5);

    checkOutput("pulse_queue_left", pulse_q.size(), 32'd0);
    checkOutput("fifo_queue_left", fifo_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
